bcd2bin: RTL and testbench
==========================

# bcd2bin

Sequential BCD-to-binary converter using reverse double-dabble (shift-right / subtract-3). It accepts three unsigned BCD digits (hundreds, tens, ones; 000–999) and returns the 10-bit binary value. It is the inverse of the display-side binary-to-BCD path, and is used where digit-entered values (menu/setpoint digits) must become binary operands. It uses the same level-held start/done handshake as the rest of the display pipeline.

## Interface
No parameters. Widths are fixed by package constants (N_DIGITS=3, BIN_W=10, N_ITER=10).
- clk  in  1  system clock, all logic on rising edge
- nrst  in  1  reset, synchronous, active-low
- start  in  1  conversion request, level-held by requester
- hundreds  in  4  BCD digit, valid 0–9
- tens  in  4  BCD digit, valid 0–9
- ones  in  4  BCD digit, valid 0–9
- bin  out  10  converted value, registered
- done  out  1  conversion complete, held until start deasserts
- err  out  1  last request had a digit >9; qualified by done
- busy  out  1  high in any state other than IDLE

## Operation
- States are IDLE, SHIFT, ADJUST and FINISHED.
- **IDLE**
  - If start=1 and done=0: latch the three digits into a 12-bit work register, clear the 10-bit shift register and iteration count.
    - If any digit >9: set err_pending and go to FINISHED.
    - Otherwise go to SHIFT.
  - If start=0 and done=1: clear done. err holds its value until the next FINISHED.
  - Start=1 with done=1 is ignored. The requester must drop start before requesting again.
- **SHIFT**
  - Shift {work[11:0], sreg[9:0]} right by 1: work[0]→sreg[9], and 0 enters work[11].
  - Next state is ADJUST.
- **ADJUST**
  - Each work nibble ≥8 gets 3 subtracted. The nibble stays 4 bits and never underflows.
  - Increment the iteration count.
  - After the 10th ADJUST go to FINISHED, otherwise go to SHIFT.
- **FINISHED**
  - Write bin <= sreg, or 0 if err_pending.
  - Set err <= err_pending and done <= 1.
  - Next state is IDLE.
- bin and err change only in FINISHED (or on reset). They are stable from done rising until the next FINISHED.
- The digit inputs are sampled only on the accepting IDLE edge. Later changes have no effect on the conversion in progress.
- Arithmetic rules:
  - The work register is fully drained after 10 iterations, because 999 < 1024.
  - The 10th ADJUST is a harmless no-op on zero nibbles.

## Timing
- Reset (nrst=0 at a rising edge): state=IDLE, bin=0, done=0, err=0, busy=0, internal registers cleared. Reset overrides any state, including mid-conversion.
- Let the accepting edge be T.
  - Valid input: SHIFT/ADJUST alternate over edges T+1..T+20. FINISHED is at T+21, so done=1 and bin is valid after edge T+21.
  - Latency is 21 cycles.
- Invalid input: FINISHED at T+1, so done=1, err=1 and bin=0 after edge T+1.
- busy is high from edge T through edge T+21 (or T+1 for invalid input) and low again once the state returns to IDLE.
- done falls at the first IDLE edge where start=0. It stays high indefinitely while start is held.
- Minimum spacing between accepted requests: done high for ≥1 cycle, start low for ≥1 edge, then start high again.
- If start drops during conversion, the conversion still completes. done then rises in FINISHED and clears on the following IDLE edge, giving a 1-cycle pulse.

## Structure
- bcd2bin_pkg holds:
  - typedef enum state_t {IDLE, SHIFT, ADJUST, FINISHED}
  - localparams N_DIGITS=3, BIN_W=10, N_ITER=10
  - a helper function returning the "digit >9" check
- Sub-module bcd_nibble_adjust: combinational, 4-bit in/out, out = (in ≥ 8) ? in−3 : in. Instantiate it three times in ADJUST.
- The top level contains the FSM, work/shift registers, iteration counter and output registers.

## Test plan
- digits 1,7,6 with start held → bin=176 (0x0B0), err=0, done rises 21 cycles after the accepting edge. busy is high throughout.
- digits 9,9,9 → bin=999 (0x3E7). Then 0,0,0 after a start toggle → bin=0, err=0.
- digits 2,0xA,5 → done after 2 edges, err=1, bin=0. A following valid 0,4,2 → bin=42 and err cleared.
- start held high for 50 cycles with 3,1,4 → exactly one conversion (bin=314) and done stays high. Change digits to 1,2,3 while start is still held → no new conversion. Drop start for 1 cycle → done=0. Reassert start → bin=123.
- nrst=0 for one edge at cycle 10 of a 9,8,7 conversion → next cycle all outputs are 0 and state is IDLE. A fresh request 9,8,7 → bin=987.
- Change the digit inputs during conversion of 5,0,0 → bin=500 regardless.

Source files
------------

// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// The work register holds one 4-bit nibble per BCD digit.
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    ADJUST   = 2'd2,
    FINISHED = 2'd3
  } state_t;

  localparam int N_DIGITS = 3;
  localparam int BIN_W    = 10;
  localparam int N_ITER   = 10;
  localparam int WORK_W   = 4 * N_DIGITS;

  function automatic logic isBadDigit(input logic [3:0] digit);
    return digit > 4'd9;
  endfunction

endpackage

// File: rtl/bcd2bin_if.sv
// Request/result bundle between a digit-entry requester and the converter.
// start is level-held by the master until done is seen.
interface bcd2bin_if;
  import bcd2bin_pkg::*;

  logic             start;
  logic [3:0]       hundreds;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic [BIN_W-1:0] bin;
  logic             done;
  logic             err;
  logic             busy;

  modport master (
    output start, hundreds, tens, ones,
    input  bin, done, err, busy
  );

  modport slave (
    input  start, hundreds, tens, ones,
    output bin, done, err, busy
  );

endinterface

// File: rtl/bcd_nibble_adjust.sv
// One nibble of the reverse double-dabble correction step.
// A nibble that reached 8+ after a right shift carried a decimal 10 down, so subtract 3.
module bcd_nibble_adjust (
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  assign o_nibble = (i_nibble >= 4'd8) ? (i_nibble - 4'd3) : i_nibble;

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter: ten shift/adjust rounds move the decimal
// work register into the binary shift register, then the result is published.
module bcd2bin
  import bcd2bin_pkg::*;
(
  input  logic      clk,
  input  logic      nrst,
  bcd2bin_if.slave  bus
);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_SHIFT    = SHIFT;
  localparam logic [1:0] ST_ADJUST   = ADJUST;
  localparam logic [1:0] ST_FINISHED = FINISHED;
  localparam logic [3:0] ITER_LAST   = 4'(N_ITER - 1);

  logic [1:0]        r_state;
  logic [WORK_W-1:0] r_work;
  logic [BIN_W-1:0]  r_sreg;
  logic [BIN_W-1:0]  r_bin;
  logic [3:0]        r_iter;
  logic              r_errPending;
  logic              r_done;
  logic              r_err;
  logic [WORK_W-1:0] w_workAdj;
  logic              w_badInput;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adjust
    bcd_nibble_adjust u_adjust (
      .i_nibble (r_work[4*g +: 4]),
      .o_nibble (w_workAdj[4*g +: 4])
    );
  end

  assign w_badInput = isBadDigit(bus.hundreds) | isBadDigit(bus.tens) | isBadDigit(bus.ones);

  // A new request is only taken once the previous done has been acknowledged by start falling.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_work       <= '0;
      r_sreg       <= '0;
      r_bin        <= '0;
      r_iter       <= '0;
      r_errPending <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start && !r_done) begin
            r_work       <= {bus.hundreds, bus.tens, bus.ones};
            r_sreg       <= '0;
            r_iter       <= '0;
            r_errPending <= w_badInput;
            r_state      <= w_badInput ? ST_FINISHED : ST_SHIFT;
          end else if (!bus.start && r_done) begin
            r_done <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_sreg  <= {r_work[0], r_sreg[BIN_W-1:1]};
          r_work  <= {1'b0, r_work[WORK_W-1:1]};
          r_state <= ST_ADJUST;
        end
        ST_ADJUST: begin
          r_work  <= w_workAdj;
          r_iter  <= r_iter + 4'd1;
          r_state <= (r_iter == ITER_LAST) ? ST_FINISHED : ST_SHIFT;
        end
        ST_FINISHED: begin
          r_bin   <= r_errPending ? '0 : r_sreg;
          r_err   <= r_errPending;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.bin  = r_bin;
  assign bus.done = r_done;
  assign bus.err  = r_err;
  assign bus.busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bcd2bin.sv
// Directed-vector bench for bcd2bin with hand-computed expected results.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bcd2bin;

  logic clk;
  logic nrst;
  int   checkCount;
  int   errorCount;

  bcd2bin_if bus ();

  bcd2bin dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    bus.hundreds = h;
    bus.tens     = t;
    bus.ones     = o;
    bus.start    = 1'b1;
  endtask

  task automatic waitDone(input int budget, input string tag);
    int n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done"}, 16'(bus.done), 16'd1);
  endtask

  task automatic dropStart(input string tag);
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_doneClr"}, 16'(bus.done), 16'd0);
  endtask

  task automatic runConversion(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                               input logic [15:0] expBin, input logic expErr, input string tag);
    applyStimulus(h, t, o);
    waitDone(40, tag);
    checkOutput({tag, "_bin"}, 16'(bus.bin), expBin);
    checkOutput({tag, "_err"}, 16'(bus.err), 16'(expErr));
    dropStart(tag);
  endtask

  initial begin
    checkCount    = 0;
    errorCount    = 0;
    nrst          = 1'b0;
    bus.start     = 1'b0;
    bus.hundreds  = 4'd0;
    bus.tens      = 4'd0;
    bus.ones      = 4'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_bin",  16'(bus.bin),  16'd0);
    checkOutput("rst_done", 16'(bus.done), 16'd0);
    checkOutput("rst_err",  16'(bus.err),  16'd0);
    checkOutput("rst_busy", 16'(bus.busy), 16'd0);
    nrst = 1'b1;
    @(negedge clk);

    // 1,7,6: exact 21-cycle latency with busy high for the whole conversion
    applyStimulus(4'd1, 4'd7, 4'd6);
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      checkOutput($sformatf("lat_busy%0d", k), 16'(bus.busy), 16'd1);
      checkOutput($sformatf("lat_done%0d", k), 16'(bus.done), 16'd0);
    end
    @(negedge clk);
    checkOutput("lat_doneRise", 16'(bus.done), 16'd1);
    checkOutput("lat_busyLow",  16'(bus.busy), 16'd0);
    checkOutput("lat_bin",      16'(bus.bin),  16'd176);
    checkOutput("lat_err",      16'(bus.err),  16'd0);
    dropStart("lat");

    runConversion(4'd9, 4'd9, 4'd9, 16'd999, 1'b0, "c999");
    runConversion(4'd0, 4'd0, 4'd0, 16'd0,   1'b0, "c000");

    // Invalid tens digit finishes after two edges with bin forced to zero
    runConversion(4'd1, 4'd2, 4'd3, 16'd123, 1'b0, "pre");
    applyStimulus(4'd2, 4'hA, 4'd5);
    @(negedge clk);
    checkOutput("bad_busy", 16'(bus.busy), 16'd1);
    checkOutput("bad_done1", 16'(bus.done), 16'd0);
    @(negedge clk);
    checkOutput("bad_done2", 16'(bus.done), 16'd1);
    checkOutput("bad_err",  16'(bus.err),  16'd1);
    checkOutput("bad_bin",  16'(bus.bin),  16'd0);
    dropStart("bad");
    checkOutput("bad_errHold", 16'(bus.err), 16'd1);
    runConversion(4'd0, 4'd4, 4'd2, 16'd42, 1'b0, "c042");

    // Held start: one conversion only, later digit changes ignored
    applyStimulus(4'd3, 4'd1, 4'd4);
    waitDone(40, "hold");
    checkOutput("hold_bin", 16'(bus.bin), 16'd314);
    repeat (10) @(negedge clk);
    bus.hundreds = 4'd1;
    bus.tens     = 4'd2;
    bus.ones     = 4'd3;
    repeat (40) @(negedge clk);
    checkOutput("hold_doneStay", 16'(bus.done), 16'd1);
    checkOutput("hold_busyLow",  16'(bus.busy), 16'd0);
    checkOutput("hold_binStay",  16'(bus.bin),  16'd314);
    dropStart("hold");
    bus.start = 1'b1;
    waitDone(40, "rearm");
    checkOutput("rearm_bin", 16'(bus.bin), 16'd123);
    dropStart("rearm");

    // Reset in the middle of a conversion, then a clean retry
    applyStimulus(4'd9, 4'd8, 4'd7);
    repeat (10) @(negedge clk);
    nrst      = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    checkOutput("mid_rst_bin",  16'(bus.bin),  16'd0);
    checkOutput("mid_rst_done", 16'(bus.done), 16'd0);
    checkOutput("mid_rst_err",  16'(bus.err),  16'd0);
    checkOutput("mid_rst_busy", 16'(bus.busy), 16'd0);
    @(negedge clk);
    runConversion(4'd9, 4'd8, 4'd7, 16'd987, 1'b0, "c987");

    // Digits change right after acceptance
    applyStimulus(4'd5, 4'd0, 4'd0);
    @(negedge clk);
    bus.hundreds = 4'd9;
    bus.tens     = 4'd9;
    bus.ones     = 4'd9;
    waitDone(40, "chg");
    checkOutput("chg_bin", 16'(bus.bin), 16'd500);
    dropStart("chg");

    // Start withdrawn mid-conversion still completes, done is a one-cycle pulse
    applyStimulus(4'd0, 4'd6, 4'd5);
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    waitDone(40, "pulse");
    checkOutput("pulse_bin", 16'(bus.bin), 16'd65);
    @(negedge clk);
    checkOutput("pulse_doneClr", 16'(bus.done), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
